uart_baud_controller: RTL and testbench

Runtime-programmable baud timing controller for the APB UART. It owns the clock divisor and sequences divisor changes so that they take effect only on bit boundaries. It produces three tick streams: an oversample tick, a TX bit tick, and an RX mid-bit sample tick that is re-phased by the receiver's start-bit detector. It sits between the APB register file (divisor writes) and the TX/RX engines.

---
 rtl/uart_baud_controller.sv | 174 +++++++++++++++++
 tb/tb_uart_baud_controller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_baud_controller.sv
// Baud timing controller for the APB UART.
// Holds the active clock divisor and produces the oversample, TX bit and RX
// mid-bit tick streams. A divisor written while running is parked and swapped
// in on the next TX bit boundary, so a character never sees a divisor change
// in the middle of a bit.
module uart_baud_controller #(
  parameter int DIV_WIDTH   = 16,
  parameter int OSR         = 16,
  parameter int DEFAULT_DIV = 27
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 cfg_wr,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  output logic                 cfg_ack,
  output logic [DIV_WIDTH-1:0] div_active,
  input  logic                 rx_restart,
  output logic                 os_tick,
  output logic                 tx_tick,
  output logic                 rx_sample_tick,
  output logic                 pending
);

  localparam int PH_W = $clog2(OSR);
  localparam logic [PH_W-1:0]      PH_LAST = PH_W'(OSR - 1);
  // rx_ph value one os_tick before it reaches OSR/2-1 (mid-bit).
  localparam logic [PH_W-1:0]      RX_PRE  = PH_W'(OSR / 2 - 2);
  localparam logic [DIV_WIDTH-1:0] MIN_DIV = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] RST_DIV = DIV_WIDTH'(DEFAULT_DIV);

  typedef enum logic [1:0] {
    S_DISABLED = 2'd0,
    S_RUN      = 2'd1,
    S_PENDING  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
  logic [PH_W-1:0]      tx_ph_q, tx_ph_d;
  logic [PH_W-1:0]      rx_ph_q, rx_ph_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] pend_div_q, pend_div_d;
  logic                 pending_q, pending_d;
  logic                 os_q, os_d;
  logic                 tx_q, tx_d;
  logic                 rx_q, rx_d;
  logic                 ack_q, ack_d;

  logic                 active;
  logic                 os_ev;
  logic                 tx_ev;
  logic [DIV_WIDTH-1:0] div_clamped;

  // Counters only run while enabled in RUN/PENDING; dropping en clears them
  // at the same edge the FSM leaves for DISABLED.
  assign active      = (state_q != S_DISABLED) && en;
  assign os_ev       = active && (pre_cnt_q == (div_q - DIV_WIDTH'(1)));
  assign tx_ev       = os_ev && (tx_ph_q == PH_LAST);
  assign div_clamped = (cfg_div < MIN_DIV) ? MIN_DIV : cfg_div;

  // Prescaler, TX/RX phase counters and the tick pulses they generate.
  always_comb begin
    pre_cnt_d = '0;
    tx_ph_d   = '0;
    rx_ph_d   = '0;
    os_d      = os_ev;
    tx_d      = tx_ev;
    // A restart landing on an os_tick wins: phase goes to 0, no sample.
    rx_d      = os_ev && !rx_restart && (rx_ph_q == RX_PRE);
    if (active) begin
      pre_cnt_d = os_ev ? '0 : pre_cnt_q + DIV_WIDTH'(1);
      tx_ph_d   = os_ev ? tx_ph_q + PH_W'(1) : tx_ph_q;
      if (rx_restart)
        rx_ph_d = '0;
      else
        rx_ph_d = os_ev ? rx_ph_q + PH_W'(1) : rx_ph_q;
    end
  end

  // Divisor sequencing FSM: direct load when idle, deferred load when running.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    pend_div_d = pend_div_q;
    pending_d  = pending_q;
    ack_d      = 1'b0;
    case (state_q)
      S_DISABLED: begin
        if (cfg_wr) begin
          div_d = div_clamped;
          ack_d = 1'b1;
        end
        if (en) state_d = S_RUN;
      end
      S_RUN: begin
        if (!en) begin
          state_d = S_DISABLED;
          if (cfg_wr) begin
            div_d = div_clamped;
            ack_d = 1'b1;
          end
        end else if (cfg_wr) begin
          pend_div_d = div_clamped;
          pending_d  = 1'b1;
          state_d    = S_PENDING;
        end
      end
      S_PENDING: begin
        if (!en) begin
          // Stopping: nothing left to protect, apply the newest value now.
          div_d     = cfg_wr ? div_clamped : pend_div_q;
          ack_d     = 1'b1;
          pending_d = 1'b0;
          state_d   = S_DISABLED;
        end else begin
          // The boundary tick itself was timed on the old divisor.
          if (tx_ev) begin
            div_d     = pend_div_q;
            ack_d     = 1'b1;
            pending_d = 1'b0;
            state_d   = S_RUN;
          end
          // A write on the boundary edge queues behind the one being applied.
          if (cfg_wr) begin
            pend_div_d = div_clamped;
            pending_d  = 1'b1;
            state_d    = S_PENDING;
          end
        end
      end
      default: begin
        state_d = S_DISABLED;
      end
    endcase
  end

  // State and output registers; reset drops any parked divisor unacked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_DISABLED;
      pre_cnt_q  <= '0;
      tx_ph_q    <= '0;
      rx_ph_q    <= '0;
      div_q      <= RST_DIV;
      pend_div_q <= '0;
      pending_q  <= 1'b0;
      os_q       <= 1'b0;
      tx_q       <= 1'b0;
      rx_q       <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      tx_ph_q    <= tx_ph_d;
      rx_ph_q    <= rx_ph_d;
      div_q      <= div_d;
      pend_div_q <= pend_div_d;
      pending_q  <= pending_d;
      os_q       <= os_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      ack_q      <= ack_d;
    end
  end

  assign cfg_ack        = ack_q;
  assign div_active     = div_q;
  assign os_tick        = os_q;
  assign tx_tick        = tx_q;
  assign rx_sample_tick = rx_q;
  assign pending        = pending_q;

endmodule

// File: tb/tb_uart_baud_controller.sv
// Bench for uart_baud_controller (OSR=4, DEFAULT_DIV=3).
// A reference model predicts when each tick / ack should appear and queues
// the cycle stamps; a monitor pops them as the DUT drives its outputs.
module tb_uart_baud_controller;

  localparam int DW   = 16;
  localparam int OSR  = 4;
  localparam int DDIV = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          cfg_wr = 1'b0;
  logic [DW-1:0] cfg_div = '0;
  logic          rx_restart = 1'b0;
  logic          cfg_ack;
  logic [DW-1:0] div_active;
  logic          os_tick, tx_tick, rx_sample_tick, pending;

  uart_baud_controller #(.DIV_WIDTH(DW), .OSR(OSR), .DEFAULT_DIV(DDIV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_wr(cfg_wr), .cfg_div(cfg_div),
    .cfg_ack(cfg_ack), .div_active(div_active), .rx_restart(rx_restart),
    .os_tick(os_tick), .tx_tick(tx_tick), .rx_sample_tick(rx_sample_tick),
    .pending(pending)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // expected event cycle stamps
  int q_os[$];
  int q_tx[$];
  int q_rx[$];
  int q_ack[$];

  // reference model state
  bit m_run, m_pend;
  int m_div, m_pend_val;
  int m_age;      // clocks elapsed in the current oversample period
  int m_bit_os;   // os_ticks elapsed in the current TX bit
  int m_rx_os;    // os_ticks since the RX phase origin

  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic check_ev(string name, bit act, bit exp);
    if (act || exp) begin
      n_chk++;
      if (act != exp) begin
        n_fail++;
        $display("FAIL %s @cyc %0d: got %0b expected %0b", name, cyc, act, exp);
      end
    end
  endtask

  function automatic int clamp(int v);
    return (v < 2) ? 2 : v;
  endfunction

  task automatic m_reset();
    m_run = 0; m_pend = 0; m_div = DDIV; m_pend_val = 0;
    m_age = 0; m_bit_os = 0; m_rx_os = 0;
    q_os.delete(); q_tx.delete(); q_rx.delete(); q_ack.delete();
  endtask

  // Reference model: one step per rising clock edge.
  initial begin
    bit act, os, tx, rx, ack;
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_reset();
      end else begin
        cyc++;
        act = m_run && en;
        os = 0; tx = 0; rx = 0; ack = 0;
        if (act) begin
          m_age++;
          if (m_age == m_div) begin os = 1; m_age = 0; end
          if (os) begin
            m_bit_os++;
            if (m_bit_os == OSR) begin tx = 1; m_bit_os = 0; end
          end
          if (rx_restart) m_rx_os = 0;
          else if (os) begin
            m_rx_os++;
            rx = ((m_rx_os % OSR) == OSR / 2 - 1);
          end
        end else begin
          m_age = 0; m_bit_os = 0; m_rx_os = 0;
        end
        if (!m_run) begin
          if (cfg_wr) begin m_div = clamp(int'(cfg_div)); ack = 1; end
          if (en) m_run = 1;
        end else if (!en) begin
          if (cfg_wr) begin m_div = clamp(int'(cfg_div)); ack = 1; end
          else if (m_pend) begin m_div = m_pend_val; ack = 1; end
          m_pend = 0;
          m_run = 0;
        end else begin
          if (tx && m_pend) begin m_div = m_pend_val; ack = 1; m_pend = 0; end
          if (cfg_wr) begin m_pend = 1; m_pend_val = clamp(int'(cfg_div)); end
        end
        if (os)  q_os.push_back(cyc);
        if (tx)  q_tx.push_back(cyc);
        if (rx)  q_rx.push_back(cyc);
        if (ack) q_ack.push_back(cyc);
      end
    end
  end

  // Monitor: compare DUT outputs against queued expectations mid-cycle.
  initial begin
    bit e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        e = (q_os.size() > 0 && q_os[0] == cyc);
        check_ev("os_tick", os_tick, e);
        if (e) void'(q_os.pop_front());
        e = (q_tx.size() > 0 && q_tx[0] == cyc);
        check_ev("tx_tick", tx_tick, e);
        if (e) void'(q_tx.pop_front());
        e = (q_rx.size() > 0 && q_rx[0] == cyc);
        check_ev("rx_sample_tick", rx_sample_tick, e);
        if (e) void'(q_rx.pop_front());
        e = (q_ack.size() > 0 && q_ack[0] == cyc);
        check_ev("cfg_ack", cfg_ack, e);
        if (e) void'(q_ack.pop_front());
        check("div_active", int'(div_active), m_div);
        check("pending", int'(pending), int'(m_pend));
      end
    end
  end

  task automatic cwait(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(int v);
    cfg_wr = 1'b1;
    cfg_div = DW'(v);
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  // Pulse rx_restart on the edge that produces the next os_tick (div=3 only).
  task automatic restart_on_os();
    int k;
    k = 0;
    while (os_tick !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) begin
      check("restart_wait_os_tick", 0, 1);
    end else begin
      cwait(2);
      rx_restart = 1'b1;
      @(negedge clk);
      rx_restart = 1'b0;
      check("restart_coincident_os_tick", int'(os_tick), 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cwait(3);
    check("rst_div_active", int'(div_active), DDIV);
    check("rst_pending", int'(pending), 0);
    check("rst_os_tick", int'(os_tick), 0);
    check("rst_tx_tick", int'(tx_tick), 0);
    check("rst_rx_sample_tick", int'(rx_sample_tick), 0);
    check("rst_cfg_ack", int'(cfg_ack), 0);
    rst_n = 1'b1;
    cwait(2);

    // steady running at the default divisor
    en = 1'b1; cwait(40);
    // write while disabled
    en = 1'b0; cwait(3);
    wr(5); cwait(5);
    wr(3); cwait(2);
    // deferred write mid-bit
    en = 1'b1; cwait(7);
    wr(6); cwait(40);
    wr(3); cwait(30);
    // two writes while pending
    wr(7); cwait(1); wr(9); cwait(60);
    wr(3); cwait(45);
    // RX re-phase coincident with os_tick
    restart_on_os(); cwait(30);
    restart_on_os(); cwait(10);
    // clamp while disabled and while running
    en = 1'b0; wr(0); cwait(2); wr(1); cwait(2);
    wr(3); cwait(1);
    en = 1'b1; cwait(5);
    wr(0); cwait(20);
    // drop en while pending
    wr(5);
    en = 1'b0; cwait(6);

    // randomized traffic
    en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      cfg_wr = ($urandom_range(0, 15) == 0);
      cfg_div = DW'($urandom_range(0, 6));
      rx_restart = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 79) == 0) en = ~en;
      @(negedge clk);
    end
    cfg_wr = 1'b0; rx_restart = 1'b0;

    // async reset with a write parked
    en = 1'b1;
    wr(3); cwait(30);
    wr(6); cwait(1);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_pending", int'(pending), 0);
    check("midrst_div_active", int'(div_active), DDIV);
    check("midrst_os_tick", int'(os_tick), 0);
    check("midrst_cfg_ack", int'(cfg_ack), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cwait(20);
    en = 1'b0; cwait(5);

    check("drain_os", q_os.size(), 0);
    check("drain_tx", q_tx.size(), 0);
    check("drain_rx", q_rx.size(), 0);
    check("drain_ack", q_ack.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
